// File: rtl/dqsw_delay_sweep_ctrl_if.sv
// Handshake and delay-line/eye-monitor control bundle for the DQSW delay sweep.
// master: the sweep controller; slave: the IOD lane / requester side.
interface dqsw_delay_sweep_ctrl_if;
  logic       START;
  logic [1:0] RX_DATA;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic       BUSY;
  logic       DONE;
  logic       FAIL;
  logic [7:0] TAP_RESULT;

  modport master (
    input  START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
    output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, FAIL, TAP_RESULT
  );

  modport slave (
    output START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
    input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, FAIL, TAP_RESULT
  );
endinterface

// File: rtl/dqsw_delay_sweep_ctrl.sv
// DQSW delay sweep: reloads the IOD delay, then per tap clears the eye flags,
// settles, samples RX_DATA and steps, until the first 0->1 transition is found
// (DONE, TAP_RESULT) or the tap range / delay line end stop is hit (FAIL).
module dqsw_delay_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4,
  parameter int MAX_TAPS      = 128
) (
  input logic                    FAB_CLK,
  input logic                    ARST_N,
  dqsw_delay_sweep_ctrl_if.master bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);
  localparam logic [7:0] TAP_LAST    = 8'(MAX_TAPS - 1);
  localparam logic [3:0] ONES_FULL   = 4'(SAMPLES);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_FIN_OK, S_FIN_ERR
  } state_t;

  state_t     state, nxt;
  logic [7:0] tap_cnt;
  logic [7:0] wait_cnt;
  logic [3:0] ones_cnt;
  logic       seen_zero;
  logic [7:0] tap_result;
  logic       hit;
  logic       load_o, move_o, clr_o, busy_o, done_o, fail_o;

  // A tap is a hit only when every sample in the window read 2'b11.
  assign hit = (ones_cnt == ONES_FULL);

  // State register.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) state <= S_IDLE;
    else         state <= nxt;
  end

  // Next-state and Moore output decode; success outranks failure in EVAL.
  always_comb begin
    nxt    = state;
    load_o = 1'b0;
    move_o = 1'b0;
    clr_o  = 1'b0;
    busy_o = 1'b1;
    done_o = 1'b0;
    fail_o = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (bus.START) nxt = S_LOAD;
      end
      S_LOAD: begin
        load_o = 1'b1;
        nxt    = S_CLEAR;
      end
      S_CLEAR: begin
        clr_o = 1'b1;
        nxt   = S_SETTLE;
      end
      S_SETTLE: if (wait_cnt == SETTLE_LAST) nxt = S_SAMPLE;
      S_SAMPLE: if (wait_cnt == SAMPLE_LAST) nxt = S_EVAL;
      S_EVAL: begin
        if (hit && seen_zero)                                 nxt = S_FIN_OK;
        else if (tap_cnt == TAP_LAST || bus.DELAY_LINE_OUT_OF_RANGE) nxt = S_FIN_ERR;
        else                                                  nxt = S_STEP;
      end
      S_STEP: begin
        move_o = 1'b1;
        nxt    = S_CLEAR;
      end
      S_FIN_OK: begin
        done_o = 1'b1;
        nxt    = S_IDLE;
      end
      S_FIN_ERR: begin
        fail_o = 1'b1;
        nxt    = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Sweep datapath: tap index, settle/sample counter, ones tally, result.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tap_cnt    <= '0;
      wait_cnt   <= '0;
      ones_cnt   <= '0;
      seen_zero  <= 1'b0;
      tap_result <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.START) begin
          tap_cnt    <= '0;
          seen_zero  <= 1'b0;
          tap_result <= '0;
        end
        S_CLEAR: begin
          wait_cnt <= '0;
          ones_cnt <= '0;
        end
        S_SETTLE: wait_cnt <= (wait_cnt == SETTLE_LAST) ? '0 : wait_cnt + 8'd1;
        S_SAMPLE: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (bus.RX_DATA == 2'b11) ones_cnt <= ones_cnt + 4'd1;
        end
        S_EVAL: begin
          if (!hit) seen_zero <= 1'b1;
          if (hit && seen_zero) tap_result <= tap_cnt;
        end
        S_STEP: tap_cnt <= tap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.DELAY_LINE_LOAD         = load_o;
  assign bus.DELAY_LINE_MOVE         = move_o;
  assign bus.DELAY_LINE_DIRECTION    = 1'b1;
  assign bus.EYE_MONITOR_CLEAR_FLAGS = clr_o;
  assign bus.BUSY                    = busy_o;
  assign bus.DONE                    = done_o;
  assign bus.FAIL                    = fail_o;
  assign bus.TAP_RESULT              = tap_result;

endmodule
